saturate_20b_to_signed: RTL and testbench
=========================================

SATURATE_20B_TO_SIGNED -- requirements
Module: saturate_20b_to_signed

Interface
REQ-001 SHALL have parameter LENGTH, default 10, output sample width in bits; legal range 2..20.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream offers in this cycle.
REQ-005 SHALL have port in  input  20  two's-complement 20-bit sample.
REQ-006 SHALL have port in_ready  output  1  block accepts in this cycle.
REQ-007 SHALL have port out_valid  output  1  out holds a valid narrowed sample.
REQ-008 SHALL have port out_ready  input  1  downstream consumes out this cycle.
REQ-009 SHALL have port out  output  LENGTH  two's-complement narrowed sample.
REQ-010 SHALL have port sat  output  1  out is a clipped value, qualified by out_valid.
REQ-011 SHALL have port sat_count  output  16  count of clipped samples consumed downstream.

Function
REQ-012 SHALL accept a sample exactly on a cycle with in_valid=1 and in_ready=1 (push).
REQ-013 SHALL consume the head entry exactly on a cycle with out_valid=1 and out_ready=1 (pop).
REQ-014 SHALL buffer accepted samples in a 2-entry FIFO holding {out, sat}; in_ready = (occupancy < 2), out_valid = (occupancy > 0).
REQ-015 SHALL narrow at push: if in > 2^(LENGTH-1)-1, store max positive with sat=1; if in < -2^(LENGTH-1), store min negative with sat=1; otherwise store in[LENGTH-1:0] with sat=0.
REQ-016 SHALL present a pushed sample on out with out_valid=1 in the cycle after the push when the FIFO was empty (latency 1).
REQ-017 SHALL keep out, sat, out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, on simultaneous push and pop at occupancy 1, keep occupancy 1 and present the new sample next cycle.
REQ-019 SHALL ignore in when occupancy is 2 (in_ready=0); no data is overwritten.
REQ-020 SHALL ignore out_ready when occupancy is 0; occupancy never underflows.
REQ-021 SHALL increment sat_count by 1 on each pop with sat=1, holding at 16'hFFFF (no wrap).
REQ-022 SHALL preserve in-order delivery; out sequence equals accepted input sequence.
REQ-023 SHALL produce out[LENGTH-1:0] = in[LENGTH-1:0] for every in-range value, including LENGTH=20 where clipping never occurs.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set occupancy 0, out_valid 0, in_ready 1 (next cycle), out 0, sat 0, sat_count 0.
REQ-025 SHALL discard all buffered samples on reset mid-operation; a push coinciding with rst=1 is dropped.
REQ-026 SHALL drive in_ready=0 during cycles with rst=1.

Configuration
REQ-027 SHALL, with macro SAT_COUNT_EN defined, implement sat_count per REQ-021.
REQ-028 SHALL, without SAT_COUNT_EN, drive sat_count constant 16'h0000 and contain no counter register; all other behaviour unchanged.

Verification
REQ-029 SHALL cover in-range: LENGTH=10, push 20'hFFE5C (-420), out_ready=1 -> next cycle out=10'h25C, sat=0, out_valid=1.
REQ-030 SHALL cover positive clip: push 20'h00400 (1024) -> out=10'h1FF, sat=1; with SAT_COUNT_EN, sat_count=1 after pop.
REQ-031 SHALL cover negative clip and boundaries: push 20'hFFC00 -> 10'h200 sat=1; 20'h001FF -> 10'h1FF sat=0; 20'hFFE00 -> 10'h200 sat=0.
REQ-032 SHALL cover backpressure: out_ready=0, push 3 samples A,B,C on consecutive cycles -> A,B accepted, in_ready=0 on third, C held upstream; release out_ready -> A,B,C delivered in order.
REQ-033 SHALL cover reset mid-operation: occupancy 2, assert rst one cycle -> out_valid=0, sat_count=0, in_ready=1 cycle after rst deasserts.
REQ-034 SHALL cover counter saturation: with SAT_COUNT_EN, 65536 clipped pops -> sat_count stays 16'hFFFF; without macro -> sat_count=0 throughout.

Source files
------------

// File: rtl/saturate_20b_to_signed.sv
// Narrows 20-bit two's-complement samples to LENGTH bits with clipping, behind a 2-entry valid/ready FIFO.
// Optional clipped-sample counter on sat_count is built only when SAT_COUNT_EN is defined.

module saturate_20b_to_signed_narrow #(
    parameter int LENGTH = 10
) (
    input  logic [19:0]       in,
    output logic [LENGTH-1:0] out,
    output logic              sat
);
    // One extra sign bit keeps the LENGTH=20 bounds representable.
    localparam logic signed [20:0] MAXV = 21'((64'sd1 <<< (LENGTH - 1)) - 64'sd1);
    localparam logic signed [20:0] MINV = 21'(-(64'sd1 <<< (LENGTH - 1)));

    logic signed [20:0] in_s;

    always_comb begin
        in_s = $signed({in[19], in});
        out  = in[LENGTH-1:0];
        sat  = 1'b0;
        if (in_s > MAXV) begin
            out = {1'b0, {(LENGTH-1){1'b1}}};
            sat = 1'b1;
        end else if (in_s < MINV) begin
            out = {1'b1, {(LENGTH-1){1'b0}}};
            sat = 1'b1;
        end
    end
endmodule

module saturate_20b_to_signed #(
    parameter int LENGTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [19:0]       in,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out,
    output logic              sat,
    output logic [15:0]       sat_count
);
    typedef struct packed {
        logic              sat;
        logic [LENGTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d, tail_q, tail_d, push_e;
    logic   push, pop;

    saturate_20b_to_signed_narrow #(.LENGTH(LENGTH)) u_narrow (
        .in  (in),
        .out (push_e.data),
        .sat (push_e.sat)
    );

    assign in_ready  = !rst && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out       = head_q.data;
    assign sat       = head_q.sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // head is always the presented entry; tail only holds the second one when FULL.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = push_e;
                end else if (push) begin
                    tail_d  = push_e;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

`ifdef SAT_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop && head_q.sat && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign sat_count = cnt_q;
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_saturate_20b_to_signed.sv
// Self-checking bench: vector table plus backpressure, reset and counter sequences,
// with a queue scoreboard checking every delivered sample against an arithmetic model.

module tb_saturate_20b_to_signed;
    localparam int L = 10;

    typedef struct {
        logic [19:0]  in;
        logic [L-1:0] exp_out;
        logic         exp_sat;
    } vec_t;

    typedef struct {
        logic [L-1:0] out;
        logic         sat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [19:0]  din = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [L-1:0] dout;
    logic         sat;
    logic [15:0]  sat_count;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   m_cnt = 0;
    vec_t vecs[12];

    saturate_20b_to_signed #(.LENGTH(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .sat       (sat),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [19:0] v);
        int   s;
        int   mx;
        int   mn;
        int   r;
        exp_t e;
        s  = v[19] ? int'(v) - (1 << 20) : int'(v);
        mx = (1 << (L - 1)) - 1;
        mn = -(1 << (L - 1));
        e.sat = 1'b1;
        if (s > mx)      r = mx;
        else if (s < mn) r = mn;
        else begin
            r = s;
            e.sat = 1'b0;
        end
        e.out = r[L-1:0];
        return e;
    endfunction

    // Scoreboard monitor: checks handshake flags and popped data mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!rst && sb.size() < 2)});
        check("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() > 0)});
        check("sat_count", {16'd0, sat_count}, m_cnt);
        if (rst) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_out", {22'd0, dout}, {22'd0, e.out});
                check("sb_sat", {31'd0, sat}, {31'd0, e.sat});
`ifdef SAT_COUNT_EN
                if (e.sat && m_cnt != 32'hFFFF) m_cnt++;
`endif
            end
            if (in_valid && in_ready) sb.push_back(model(din));
        end
    end

    task automatic push(input logic [19:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        din = v;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{20'hFFE5C, 10'h25C, 1'b0};
        vecs[1]  = '{20'h00400, 10'h1FF, 1'b1};
        vecs[2]  = '{20'hFFC00, 10'h200, 1'b1};
        vecs[3]  = '{20'h001FF, 10'h1FF, 1'b0};
        vecs[4]  = '{20'hFFE00, 10'h200, 1'b0};
        vecs[5]  = '{20'h00000, 10'h000, 1'b0};
        vecs[6]  = '{20'h7FFFF, 10'h1FF, 1'b1};
        vecs[7]  = '{20'h80000, 10'h200, 1'b1};
        vecs[8]  = '{20'hFFFFF, 10'h3FF, 1'b0};
        vecs[9]  = '{20'h00200, 10'h1FF, 1'b1};
        vecs[10] = '{20'hFFDFF, 10'h200, 1'b1};
        vecs[11] = '{20'h00123, 10'h123, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out", {22'd0, dout}, 32'd0);
        check("rst_sat", {31'd0, sat}, 32'd0);
        check("rst_sat_count", {16'd0, sat_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Table vectors: latency-1 presentation with out_ready high.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            push(vecs[i].in);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_out", i), {22'd0, dout}, {22'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_sat", i), {31'd0, sat}, {31'd0, vecs[i].exp_sat});
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: A, B fill the FIFO, C waits upstream; outputs stay stable.
        out_ready = 1'b0;
        in_valid = 1'b1;
        din = 20'h00011;
        @(posedge clk);
        #1 din = 20'h00500;
        @(posedge clk);
        #1 din = 20'hFFF00;
        @(negedge clk);
        check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        check("bp_head_out", {22'd0, dout}, 32'h011);
        @(posedge clk);
        @(negedge clk);
        check("bp_head_stable", {22'd0, dout}, 32'h011);
        check("bp_sat_stable", {31'd0, sat}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        push(20'hFFF00);
        drain();

        // Simultaneous push/pop at occupancy 1 keeps one entry and shows the new sample.
        out_ready = 1'b1;
        in_valid = 1'b1;
        din = 20'h00055;
        @(posedge clk);
        #1 din = 20'hFF000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pp_out", {22'd0, dout}, 32'h200);
        check("pp_sat", {31'd0, sat}, 32'd1);
        drain();

        // Reset with the FIFO full and a coinciding push.
        out_ready = 1'b0;
        push(20'h00400);
        push(20'h00033);
        rst = 1'b1;
        in_valid = 1'b1;
        din = 20'h00077;
        @(negedge clk);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("after_rst_sat_count", {16'd0, sat_count}, 32'd0);
        check("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("after_rst_out", {22'd0, dout}, 32'd0);
        @(posedge clk);
        #1;

        // Continuous clipped traffic for the counter.
        out_ready = 1'b1;
        in_valid = 1'b1;
        din = 20'h00400;
`ifdef SAT_COUNT_EN
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        check("cnt_saturated", {16'd0, sat_count}, 32'hFFFF);
`else
        repeat (300) @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        check("cnt_disabled", {16'd0, sat_count}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
